// File: rtl/booth_mul_arbiter_if.sv
// Client/multiplier-facing signals of booth_mul_arbiter.
// The arbiter uses the slave view; the clients and the multiplier use the master view.
interface booth_mul_arbiter_if #(
  parameter int NREQ = 4,
  parameter int W    = 4
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   gnt;
  logic              busy;
  logic              mul_start;
  logic [W-1:0]      mul_a;
  logic [W-1:0]      mul_b;
  logic              mul_valid;
  logic [2*W-1:0]    mul_c;
  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic [2*W-1:0]    rsp_c;
  logic              rsp_err;

  modport slave (
    input  req, req_a, req_b, mul_valid, mul_c,
    output gnt, busy, mul_start, mul_a, mul_b, rsp_valid, rsp_id, rsp_c, rsp_err
  );

  modport master (
    output req, req_a, req_b, mul_valid, mul_c,
    input  gnt, busy, mul_start, mul_a, mul_b, rsp_valid, rsp_id, rsp_c, rsp_err
  );
endinterface

// File: rtl/booth_mul_arbiter.sv
// Round-robin arbiter sharing one signed Booth multiplier between NREQ clients.
// IDLE: wait for req | ISSUE: gnt + mul_start | WAIT: poll mul_valid / timeout | RESP: rsp_valid pulse
module booth_mul_arbiter #(
  parameter int NREQ    = 4,
  parameter int W       = 4,
  parameter int TIMEOUT = 32,
  parameter int BLANK   = 2
) (
  input logic                clk,
  input logic                reset,
  booth_mul_arbiter_if.slave bus
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            busy_q, busy_d;
  logic            mul_start_q, mul_start_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            rsp_err_q, rsp_err_d;
  logic [W-1:0]    mul_a_q, mul_a_d;
  logic [W-1:0]    mul_b_q, mul_b_d;
  logic [2*W-1:0]  rsp_c_q, rsp_c_d;

  logic            found;
  logic [IDW-1:0]  winner;
  logic [IDW:0]    probe;
  logic [W-1:0]    sel_a, sel_b;

  // Search starts just past the last winner and wraps modulo NREQ.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    probe  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      probe = {1'b0, rr_ptr_q} + (IDW+1)'(k);
      if (probe >= (IDW+1)'(NREQ)) probe = probe - (IDW+1)'(NREQ);
      if (!found && bus.req[probe[IDW-1:0]]) begin
        found  = 1'b1;
        winner = probe[IDW-1:0];
      end
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (winner == IDW'(i)) begin
        sel_a = bus.req_a[i*W +: W];
        sel_b = bus.req_b[i*W +: W];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    id_d        = id_q;
    cnt_d       = cnt_q;
    gnt_d       = '0;
    mul_start_d = 1'b0;
    rsp_valid_d = 1'b0;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    rsp_id_d    = rsp_id_q;
    rsp_c_d     = rsp_c_q;
    rsp_err_d   = rsp_err_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d     = ISSUE;
          rr_ptr_d    = winner;
          id_d        = winner;
          mul_a_d     = sel_a;
          mul_b_d     = sel_b;
          gnt_d       = NREQ'(1) << winner;
          mul_start_d = 1'b1;
        end
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        // A valid seen on the timeout cycle still counts as a good result.
        if ((cnt_q >= CW'(BLANK)) && bus.mul_valid) begin
          state_d     = RESP;
          rsp_c_d     = bus.mul_c;
          rsp_err_d   = 1'b0;
          rsp_id_d    = id_q;
          rsp_valid_d = 1'b1;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d     = RESP;
          rsp_c_d     = '0;
          rsp_err_d   = 1'b1;
          rsp_id_d    = id_q;
          rsp_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= IDW'(NREQ - 1);
      id_q        <= '0;
      cnt_q       <= '0;
      gnt_q       <= '0;
      busy_q      <= 1'b0;
      mul_start_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      rsp_id_q    <= '0;
      rsp_c_q     <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      id_q        <= id_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      busy_q      <= busy_d;
      mul_start_q <= mul_start_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      rsp_id_q    <= rsp_id_d;
      rsp_c_q     <= rsp_c_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.busy      = busy_q;
  assign bus.mul_start = mul_start_q;
  assign bus.mul_a     = mul_a_q;
  assign bus.mul_b     = mul_b_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_c     = rsp_c_q;
  assign bus.rsp_err   = rsp_err_q;
endmodule
